// File: rtl/btn_conditioner.sv
// Push-button conditioner: two-flop synchroniser, per-channel debounce FSM,
// registered press/release pulses and a press-then-auto-repeat pulse stream.
module btn_conditioner #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCNT_W  = $clog2(REP_MAX);

  localparam logic [CNT_W-1:0]  CNT_LAST        = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCNT_W-1:0] REP_DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] REP_PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RELEASED,
    ARMING,
    PRESSED,
    DISARMING
  } state_e;

  logic [N_BTN-1:0] s1_q, s1_d;
  logic [N_BTN-1:0] s2_q, s2_d;

  always_comb begin
    s1_d = btn_raw;
    s2_d = s1_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RCNT_W-1:0]  rcnt_q, rcnt_d;
    logic               rphase_q, rphase_d;
    logic               level_q, level_d;
    logic               press_q, press_d;
    logic               release_q, release_d;
    logic               repeat_q, repeat_d;
    logic               rep_hit;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      repeat_d  = 1'b0;
      rcnt_d    = rcnt_q;
      rphase_d  = rphase_q;
      rep_hit   = rphase_q ? (rcnt_q == REP_PERIOD_LAST) : (rcnt_q == REP_DELAY_LAST);

      // Repeat timer runs on the current level; FSM edges below override it.
      if (level_q) begin
        if (rep_hit) begin
          repeat_d = 1'b1;
          rcnt_d   = '0;
          rphase_d = 1'b1;
        end else begin
          rcnt_d = rcnt_q + RCNT_W'(1);
        end
      end else begin
        rcnt_d   = '0;
        rphase_d = 1'b0;
      end

      unique case (state_q)
        RELEASED: begin
          if (s2_q[g]) begin
            state_d = ARMING;
            cnt_d   = '0;
          end
        end
        ARMING: begin
          if (!s2_q[g]) begin
            state_d = RELEASED;
          end else if (cnt_q == CNT_LAST) begin
            state_d  = PRESSED;
            level_d  = 1'b1;
            press_d  = 1'b1;
            repeat_d = 1'b1;
            rcnt_d   = '0;
            rphase_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!s2_q[g]) begin
            state_d = DISARMING;
            cnt_d   = '0;
          end
        end
        DISARMING: begin
          if (s2_q[g]) begin
            state_d = PRESSED;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = RELEASED;
            level_d   = 1'b0;
            release_d = 1'b1;
            repeat_d  = 1'b0;
            rcnt_d    = '0;
            rphase_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = RELEASED;
      endcase
    end

    always_ff @(posedge CLK) begin
      if (reset) begin
        state_q   <= RELEASED;
        cnt_q     <= '0;
        rcnt_q    <= '0;
        rphase_q  <= 1'b0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        rcnt_q    <= rcnt_d;
        rphase_q  <= rphase_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        repeat_q  <= repeat_d;
      end
    end

    assign btn_level[g]   = level_q;
    assign btn_press[g]   = press_q;
    assign btn_release[g] = release_q;
    assign btn_repeat[g]  = repeat_q;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: expected pulse events are queued from
// the stimulus timeline and matched against pulses seen on each falling edge.
module tb_btn_conditioner;

  localparam int N   = 5;
  localparam int DB  = 4;
  localparam int RD  = 10;
  localparam int RP  = 5;
  // Raw change driven at negedge with cyc=c shows up on outputs after edge c+LAT.
  localparam int LAT = DB + 3;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_REP   = 2;

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } ev_t;

  logic         clk;
  logic         reset;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_repeat;

  int  cyc;
  int  n_cmp;
  int  n_bad;
  ev_t exp_q[$];

  btn_conditioner #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .CLK        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // Every observed pulse pops the head of the expected queue.
  always @(negedge clk) begin : mon
    ev_t  o;
    ev_t  e;
    logic hit;
    for (int ch = 0; ch < N; ch++) begin
      for (int k = 0; k < 3; k++) begin
        hit = (k == K_PRESS) ? btn_press[ch] : (k == K_REL) ? btn_release[ch] : btn_repeat[ch];
        if (hit === 1'b1) begin
          o = '{cyc, ch, k};
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got cyc=%0d ch=%0d kind=%0d want none", o.cyc, o.ch, o.kind);
          end else begin
            e = exp_q.pop_front();
            if (o.cyc !== e.cyc || o.ch !== e.ch || o.kind !== e.kind) begin
              n_bad++;
              $display("FAIL event: got cyc=%0d ch=%0d kind=%0d want cyc=%0d ch=%0d kind=%0d",
                       o.cyc, o.ch, o.kind, e.cyc, e.ch, e.kind);
            end
          end
        end
      end
    end
  end

  function automatic int ev_key(input ev_t e);
    return e.cyc * 64 + e.ch * 4 + e.kind;
  endfunction

  task automatic push_exp(input int c, input int ch, input int kind);
    ev_t e;
    int  i;
    e = '{c, ch, kind};
    i = 0;
    while (i < exp_q.size() && ev_key(exp_q[i]) <= ev_key(e)) i++;
    exp_q.insert(i, e);
  endtask

  // Press accepted at edge p, released at edge r: press+repeat at p, repeats
  // after RD then every RP while level is high, release at r.
  task automatic exp_hold(input int ch, input int p, input int r);
    int t;
    push_exp(p, ch, K_PRESS);
    push_exp(p, ch, K_REP);
    t = p + RD;
    while (t < r) begin
      push_exp(t, ch, K_REP);
      t += RP;
    end
    push_exp(r, ch, K_REL);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic test_reset();
    wait_until(3);
    n_cmp++;
    if (btn_level !== '0) begin
      n_bad++; $display("FAIL reset_level: got %b want %b", btn_level, 5'b0);
    end
    n_cmp++;
    if (btn_press !== '0) begin
      n_bad++; $display("FAIL reset_press: got %b want %b", btn_press, 5'b0);
    end
    n_cmp++;
    if (btn_release !== '0) begin
      n_bad++; $display("FAIL reset_release: got %b want %b", btn_release, 5'b0);
    end
    n_cmp++;
    if (btn_repeat !== '0) begin
      n_bad++; $display("FAIL reset_repeat: got %b want %b", btn_repeat, 5'b0);
    end
    reset = 1'b0;
    wait_until(cyc + 3);
  endtask

  task automatic test_clean_press();
    int c, p, f, r;
    c = cyc; p = c + LAT; f = p + 12; r = f + LAT;
    exp_hold(1, p, r);
    btn_raw[1] = 1'b1;
    wait_until(p - 1);
    n_cmp++;
    if (btn_level !== 5'b00000) begin
      n_bad++; $display("FAIL clean_level_early: got %b want %b", btn_level, 5'b00000);
    end
    wait_until(p);
    n_cmp++;
    if (btn_level !== 5'b00010) begin
      n_bad++; $display("FAIL clean_level_press: got %b want %b", btn_level, 5'b00010);
    end
    wait_until(f);
    btn_raw[1] = 1'b0;
    wait_until(r - 1);
    n_cmp++;
    if (btn_level !== 5'b00010) begin
      n_bad++; $display("FAIL clean_level_hold: got %b want %b", btn_level, 5'b00010);
    end
    wait_until(r);
    n_cmp++;
    if (btn_level !== 5'b00000) begin
      n_bad++; $display("FAIL clean_level_release: got %b want %b", btn_level, 5'b00000);
    end
    wait_until(r + 3);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL clean_missing: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_bounce();
    int c, p, f, r;
    c = cyc; p = c + 10; f = p + 15; r = f + LAT;
    exp_hold(0, p, r);
    btn_raw[0] = 1'b1;
    wait_until(c + 2);
    btn_raw[0] = 1'b0;
    wait_until(c + 3);
    btn_raw[0] = 1'b1;
    wait_until(c + LAT);
    n_cmp++;
    if (btn_level !== 5'b00000) begin
      n_bad++; $display("FAIL bounce_no_early: got %b want %b", btn_level, 5'b00000);
    end
    wait_until(p - 1);
    n_cmp++;
    if (btn_level !== 5'b00000) begin
      n_bad++; $display("FAIL bounce_before_accept: got %b want %b", btn_level, 5'b00000);
    end
    wait_until(p);
    n_cmp++;
    if (btn_level !== 5'b00001) begin
      n_bad++; $display("FAIL bounce_accept: got %b want %b", btn_level, 5'b00001);
    end
    wait_until(f);
    btn_raw[0] = 1'b0;
    wait_until(r + 3);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL bounce_missing: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_glitch_release();
    int c, p, g, f, r;
    c = cyc; p = c + LAT; g = c + 30; f = c + 43; r = f + LAT;
    exp_hold(3, p, r);
    btn_raw[3] = 1'b1;
    wait_until(g);
    btn_raw[3] = 1'b0;
    wait_until(g + 2);
    btn_raw[3] = 1'b1;
    for (int i = 3; i <= 6; i++) begin
      wait_until(g + i);
      n_cmp++;
      if (btn_level !== 5'b01000) begin
        n_bad++; $display("FAIL glitch_level_%0d: got %b want %b", i, btn_level, 5'b01000);
      end
    end
    wait_until(f);
    btn_raw[3] = 1'b0;
    wait_until(r - 1);
    n_cmp++;
    if (btn_level !== 5'b01000) begin
      n_bad++; $display("FAIL release_level_hold: got %b want %b", btn_level, 5'b01000);
    end
    wait_until(r);
    n_cmp++;
    if (btn_level !== 5'b00000) begin
      n_bad++; $display("FAIL release_level_low: got %b want %b", btn_level, 5'b00000);
    end
    wait_until(r + 3);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL glitch_missing: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_auto_repeat();
    int c, p, f, r;
    c = cyc; p = c + LAT; f = p + 32; r = f + LAT;
    exp_hold(4, p, r);
    btn_raw[4] = 1'b1;
    wait_until(f);
    btn_raw[4] = 1'b0;
    wait_until(r);
    n_cmp++;
    if (btn_level !== 5'b00000) begin
      n_bad++; $display("FAIL repeat_level_low: got %b want %b", btn_level, 5'b00000);
    end
    wait_until(r + 12);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL repeat_missing: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int c, p, p2, f, r;
    c = cyc; p = c + LAT; p2 = p + 11; f = p + 15; r = f + LAT;
    push_exp(p, 2, K_PRESS);
    push_exp(p, 2, K_REP);
    btn_raw[2] = 1'b1;
    wait_until(p + 3);
    reset = 1'b1;
    wait_until(p + 4);
    reset = 1'b0;
    exp_hold(2, p2, r);
    n_cmp++;
    if ({btn_level, btn_press, btn_release, btn_repeat} !== '0) begin
      n_bad++; $display("FAIL reset_mid_outputs: got %b %b %b %b want all 0",
                        btn_level, btn_press, btn_release, btn_repeat);
    end
    wait_until(p2 - 1);
    n_cmp++;
    if (btn_level !== 5'b00000) begin
      n_bad++; $display("FAIL reset_requal_early: got %b want %b", btn_level, 5'b00000);
    end
    wait_until(p2);
    n_cmp++;
    if (btn_level !== 5'b00100) begin
      n_bad++; $display("FAIL reset_requal_press: got %b want %b", btn_level, 5'b00100);
    end
    wait_until(f);
    btn_raw[2] = 1'b0;
    wait_until(r + 3);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL reset_missing: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_multi_channel();
    int c, p, f4, r4, f0, r0;
    c = cyc; p = c + LAT; f4 = p + 4; r4 = f4 + LAT; f0 = p + 20; r0 = f0 + LAT;
    exp_hold(4, p, r4);
    exp_hold(0, p, r0);
    btn_raw[0] = 1'b1;
    btn_raw[4] = 1'b1;
    wait_until(p);
    n_cmp++;
    if (btn_press !== 5'b10001) begin
      n_bad++; $display("FAIL multi_press: got %b want %b", btn_press, 5'b10001);
    end
    wait_until(f4);
    btn_raw[4] = 1'b0;
    wait_until(r4 - 1);
    n_cmp++;
    if (btn_level !== 5'b10001) begin
      n_bad++; $display("FAIL multi_level_both: got %b want %b", btn_level, 5'b10001);
    end
    wait_until(r4);
    n_cmp++;
    if (btn_level !== 5'b00001) begin
      n_bad++; $display("FAIL multi_level_ch0: got %b want %b", btn_level, 5'b00001);
    end
    wait_until(f0);
    btn_raw[0] = 1'b0;
    wait_until(r0);
    n_cmp++;
    if (btn_level !== 5'b00000) begin
      n_bad++; $display("FAIL multi_level_none: got %b want %b", btn_level, 5'b00000);
    end
    wait_until(r0 + 3);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL multi_missing: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    cyc     = 0;
    n_cmp   = 0;
    n_bad   = 0;
    reset   = 1'b1;
    btn_raw = '0;
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch_release();
    test_auto_repeat();
    test_reset_mid();
    test_multi_channel();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Input conditioning stage between the Basys3 push-buttons (BTNU/BTNL/BTND/BTNR/BTNC) and the Pong `Game` block. Each raw asynchronous button is synchronised into the `CLK` domain and debounced by a per-channel state machine. Each channel produces a clean level for paddle control, one-cycle press/release pulses, and an auto-repeat pulse for menu/score stepping. All channels are independent and identical.

## Interface
- `N_BTN`, 5: number of button channels; bit order {BTNC, BTNR, BTND, BTNL, BTNU} = [4:0].
- `DEBOUNCE_CYCLES`, 1_000_000: stable-input cycles required before a level change is accepted (10 ms at 100 MHz); must be >= 2.
- `REPEAT_DELAY`, 50_000_000: cycles from accepted press to first auto-repeat pulse; must be >= 2.
- `REPEAT_PERIOD`, 10_000_000: cycles between subsequent auto-repeat pulses; must be >= 2.

- `CLK` in 1: 100 MHz system clock; all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `btn_raw` in N_BTN: raw asynchronous button inputs.
- `btn_level` out N_BTN: debounced level, 1 = held.
- `btn_press` out N_BTN: one-cycle pulse on accepted press.
- `btn_release` out N_BTN: one-cycle pulse on accepted release.
- `btn_repeat` out N_BTN: one-cycle pulse on press, then auto-repeat while held.

## Operation
- Synchroniser: two flops per channel (`s1`, `s2`). Only `s2` is used by the FSM. Both reset to 0.
- Per-channel FSM, debounce counter `cnt` of width clog2(DEBOUNCE_CYCLES):
  - RELEASED: `s2`=1 -> ARMING, `cnt`<=0.
  - ARMING: `s2`=0 -> RELEASED with no pulse. Otherwise, if `cnt`==DEBOUNCE_CYCLES-1 -> PRESSED, `btn_level`<=1, `btn_press`/`btn_repeat` pulse. Otherwise `cnt`++.
  - PRESSED: `s2`=0 -> DISARMING, `cnt`<=0.
  - DISARMING: `s2`=1 -> PRESSED with no pulse and level unchanged. Otherwise, if `cnt`==DEBOUNCE_CYCLES-1 -> RELEASED, `btn_level`<=0, `btn_release` pulse. Otherwise `cnt`++.
- `btn_level` is 1 exactly in PRESSED and DISARMING. Glitches shorter than DEBOUNCE_CYCLES never change it.
- Auto-repeat, per channel: counter `rcnt` and flag `rphase`.
  - Both are cleared on the press-accept edge.
  - While `btn_level`=1, `rcnt`++ each cycle. When `rcnt` reaches the threshold (REPEAT_DELAY-1 if `rphase`=0, else REPEAT_PERIOD-1): `btn_repeat` pulses, `rcnt`<=0, `rphase`<=1.
  - While `btn_level`=0, `rcnt` and `rphase` are held at 0.
  - Repeat continues through DISARMING; it stops on the edge `btn_level` falls.
- `btn_press`, `btn_release` and `btn_repeat` are registered and high for exactly one `CLK` cycle.
- `btn_press` and `btn_release` never assert together on one channel.
- Simultaneous events on different channels are fully independent.
- Reset, at any time including mid-press or mid-count: all FSMs go to RELEASED; all counters, flags and outputs go to 0.
  - A button held through reset deassertion is re-qualified from ARMING and produces a fresh `btn_press`.
- `Game` samples levels on the slow game clock. Paddle inputs therefore use `btn_level`; pulse outputs are for `CLK`-domain consumers only.

## Timing
- Reset values: `btn_level`=0, `btn_press`=0, `btn_release`=0, `btn_repeat`=0.
- Press latency: `btn_raw` rises before edge k and stays stable.
  - `s2`=1 after edge k+1; ARMING entered at edge k+2.
  - `btn_level` and `btn_press` go high after edge k+2+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 cycles.
- Release latency is symmetric: DEBOUNCE_CYCLES+2 cycles to `btn_level`=0 and `btn_release`=1.
- First auto-repeat pulse follows the press pulse by REPEAT_DELAY cycles; subsequent pulses are every REPEAT_PERIOD cycles.
- Minimum accepted press width: DEBOUNCE_CYCLES+1 cycles of stable `s2`=1. A bounce of 0 for even one sampled cycle during ARMING restarts qualification.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
- Clean press: `btn_raw[1]` 0->1 before edge 0, held -> `btn_level[1]`=1 and `btn_press[1]`=1 for one cycle after edge 6. Other bits stay 0.
- Bounce rejection: `btn_raw[0]` pattern 1,1,0,1,1,1,1,1... starting edge 0 -> no press at edge 6; press accepted after edge 9; exactly one `btn_press` pulse.
- Release and glitch: hold for 30 cycles, then a 2-cycle 0 glitch -> `btn_level` stays 1, no pulse. Then a sustained 0 -> `btn_release` one cycle, `btn_level`=0 six cycles after the falling edge.
- Auto-repeat: hold 40 cycles after press accept at edge P -> `btn_repeat` pulses at P, P+10, P+15, P+20, P+25, P+30, P+35. Pulses stop within one cycle of `btn_level` falling.
- Reset mid-operation: assert `reset` for 1 cycle while channel 2 is in PRESSED with the button held -> all outputs 0 the cycle after. `btn_press[2]` re-fires 6 cycles after reset deassertion.
- Multi-channel: press channels 0 and 4 on the same edge -> both `btn_press` pulses occur on the same cycle. Release of channel 4 does not disturb channel 0.
